// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   loader_state_t : loader FSM states
//   DEFAULT_MAGIC  : default frame start byte
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } loader_state_t;

   localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-RAM write port and core control.
//   in_valid/in_data/in_ready : byte handshake (host -> loader)
//   imem_we/imem_addr/imem_wd : RAM word write port (loader -> RAM)
//   core_reset/done/error     : core reset hold and load status
// Modports: master = host/RAM side, slave = loader.
interface imem_loader_if #(
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wd;
   logic          core_reset;
   logic          done;
   logic          error;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wd, core_reset, done, error
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wd, core_reset, done, error
   );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs bytes into a 32-bit little-endian word register.
//   clk     : clock
//   i_byte  : byte to store
//   i_idx   : byte lane; lane k fills bits [8k+7:8k]
//   i_load  : store i_byte into lane i_idx
//   i_clear : synchronous clear of the whole word (wins over i_load)
//   o_word  : assembled word
module byte_assembler (
   input  logic        clk,
   input  logic [7:0]  i_byte,
   input  logic [1:0]  i_idx,
   input  logic        i_load,
   input  logic        i_clear,
   output logic [31:0] o_word
);

   logic [31:0] r_word;

   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_word <= '0;
      end else if (i_load) begin
         r_word[{i_idx, 3'b000} +: 8] <= i_byte;
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives framed bytes (MAGIC, COUNT, COUNT*4 payload bytes,
// XOR checksum), writes little-endian words into instruction RAM and holds
// the core in reset until a verified image is loaded.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : byte stream, RAM write port and status (slave modport)
module imem_loader
   import loader_pkg::*;
#(
   parameter int         DEPTH = 64,
   parameter logic [7:0] MAGIC = DEFAULT_MAGIC
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   loader_state_t r_state, w_state_nxt;

   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wd_hold;
   logic          r_core_reset;
   logic          r_done;
   logic          r_error;
   logic [7:0]    r_count;
   logic [7:0]    r_widx;
   logic [1:0]    r_bidx;
   logic [7:0]    r_chk;

   logic          w_xfer;
   logic          w_is_magic;
   logic          w_start;
   logic          w_cnt_ok;
   logic          w_cnt_bad;
   logic          w_load;
   logic          w_word_end;
   logic          w_chk_ok;
   logic          w_chk_bad;
   logic [31:0]   w_word;

   // No byte is accepted during the write cycle.
   assign w_xfer     = bus.in_valid & ~r_we;
   assign w_is_magic = (bus.in_data == MAGIC);

   byte_assembler u_asm (
      .clk     (clk),
      .i_byte  (bus.in_data),
      .i_idx   (r_bidx),
      .i_load  (w_load),
      .i_clear (reset | w_cnt_ok),
      .o_word  (w_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_cnt_ok    = 1'b0;
      w_cnt_bad   = 1'b0;
      w_load      = 1'b0;
      w_word_end  = 1'b0;
      w_chk_ok    = 1'b0;
      w_chk_bad   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (w_xfer && w_is_magic) begin
               w_state_nxt = S_COUNT;
               w_start     = 1'b1;
            end
         end
         S_COUNT: begin
            if (w_xfer) begin
               if ((bus.in_data == 8'd0) || ({1'b0, bus.in_data} > DEPTH_W)) begin
                  w_state_nxt = S_ERR;
                  w_cnt_bad   = 1'b1;
               end else begin
                  w_state_nxt = S_DATA;
                  w_cnt_ok    = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (w_xfer) begin
               w_load = 1'b1;
               if (r_bidx == 2'd3) begin
                  w_word_end = 1'b1;
                  if (r_widx == r_count - 8'd1) begin
                     w_state_nxt = S_CHECK;
                  end
               end
            end
         end
         S_CHECK: begin
            if (w_xfer) begin
               if (bus.in_data == r_chk) begin
                  w_state_nxt = S_DONE;
                  w_chk_ok    = 1'b1;
               end else begin
                  w_state_nxt = S_ERR;
                  w_chk_bad   = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wd_hold    <= '0;
         r_core_reset <= 1'b1;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_count      <= '0;
         r_widx       <= '0;
         r_bidx       <= '0;
         r_chk        <= '0;
      end else begin
         r_we <= w_word_end;
         if (w_start) begin
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
         end
         if (w_cnt_ok) begin
            r_count <= bus.in_data;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_chk   <= '0;
         end
         if (w_load) begin
            r_chk  <= r_chk ^ bus.in_data;
            r_bidx <= r_bidx + 2'd1;
         end
         if (w_word_end) begin
            r_addr <= r_widx[AW-1:0];
            r_widx <= r_widx + 8'd1;
         end
         if (r_we) begin
            r_wd_hold <= w_word;
         end
         if (w_cnt_bad || w_chk_bad) begin
            r_error <= 1'b1;
         end
         if (w_chk_ok) begin
            r_done       <= 1'b1;
            r_core_reset <= 1'b0;
         end
      end
   end

   // The assembled word is complete during the write cycle; afterwards the
   // assembler starts on the next word, so a copy keeps imem_wd stable.
   assign bus.in_ready   = ~r_we;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wd    = r_we ? w_word : r_wd_hold;
   assign bus.core_reset = r_core_reset;
   assign bus.done       = r_done;
   assign bus.error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

   localparam int DEPTH = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int bp_viol  = 0;

   logic [5:0]  wr_addr [$];
   logic [31:0] wr_data [$];
   int          wr_cyc  [$];
   int          xfer4_cyc [$];
   logic [31:0] pay [0:63];

   imem_loader_if #(.DEPTH(DEPTH)) bus ();

   imem_loader #(.DEPTH(DEPTH), .MAGIC(8'hA5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write capture and backpressure observation, away from the active edge.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_addr.push_back(bus.imem_addr);
         wr_data.push_back(bus.imem_wd);
         wr_cyc.push_back(cyc);
      end
      if (bus.in_ready !== ~bus.imem_we) bp_viol++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   // Offers a byte from a falling edge and holds it until accepted.
   // xc is the cycle number of the accepting edge's cycle.
   task automatic send_byte(input logic [7:0] b, output int xc);
      bit sent;
      sent = 1'b0;
      xc   = -1;
      for (int n = 0; n < 16 && !sent; n++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = b;
         if (bus.in_ready === 1'b1) begin
            sent = 1'b1;
            xc   = cyc;
         end
      end
      n_checks++;
      if (!sent) begin
         n_fail++;
         $display("FAIL send_byte: in_ready low for 16 cycles, byte %02h not accepted", b);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_byte_gap(input logic [7:0] b, input int gap, output int xc);
      repeat (gap) @(negedge clk);
      send_byte(b, xc);
   endtask

   task automatic send_frame(input logic [7:0] cnt, input int nw,
                             input logic [7:0] chk_flip, input int max_gap);
      logic [7:0] b;
      logic [7:0] chk;
      int xc;
      chk = '0;
      xfer4_cyc.delete();
      send_byte_gap(8'hA5, 0, xc);
      send_byte_gap(cnt, 0, xc);
      for (int w = 0; w < nw; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = pay[w][8*k +: 8];
            chk = chk ^ b;
            send_byte_gap(b, int'($urandom_range(max_gap, 0)), xc);
            if (k == 3) xfer4_cyc.push_back(xc);
         end
      end
      send_byte_gap(chk ^ chk_flip, 0, xc);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.core_reset !== 1'b1) begin n_fail++; $display("FAIL reset core_reset: got %b want 1", bus.core_reset); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.done); end
      n_checks++;
      if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset error: got %b want 0", bus.error); end
      n_checks++;
      if (bus.imem_we !== 1'b0) begin n_fail++; $display("FAIL reset imem_we: got %b want 0", bus.imem_we); end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
      n_checks++;
      if (bus.imem_addr !== 6'd0) begin n_fail++; $display("FAIL reset imem_addr: got %0d want 0", bus.imem_addr); end
      n_checks++;
      if (bus.imem_wd !== 32'd0) begin n_fail++; $display("FAIL reset imem_wd: got %08h want 0", bus.imem_wd); end
      reset = 1'b0;
   endtask

   task automatic test_two_word();
      pay[0] = 32'hE3000001;
      pay[1] = 32'hE3A00002;
      @(posedge clk);
      clear_log();
      send_frame(8'd2, 2, 8'h00, 0);
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL two_word done: got %b want 1", bus.done); end
      n_checks++;
      if (bus.core_reset !== 1'b0) begin n_fail++; $display("FAIL two_word core_reset: got %b want 0", bus.core_reset); end
      n_checks++;
      if (bus.error !== 1'b0) begin n_fail++; $display("FAIL two_word error: got %b want 0", bus.error); end
      n_checks++;
      if (wr_addr.size() !== 2) begin
         n_fail++; $display("FAIL two_word write_count: got %0d want 2", wr_addr.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (wr_addr[i] !== 6'(i)) begin n_fail++; $display("FAIL two_word addr[%0d]: got %0d want %0d", i, wr_addr[i], i); end
            n_checks++;
            if (wr_data[i] !== pay[i]) begin n_fail++; $display("FAIL two_word data[%0d]: got %08h want %08h", i, wr_data[i], pay[i]); end
            n_checks++;
            if (wr_cyc[i] !== xfer4_cyc[i] + 1) begin n_fail++; $display("FAIL two_word latency[%0d]: got cycle %0d want %0d", i, wr_cyc[i], xfer4_cyc[i] + 1); end
         end
      end
      n_checks++;
      if (bus.imem_wd !== 32'hE3A00002) begin n_fail++; $display("FAIL two_word wd_hold: got %08h want E3A00002", bus.imem_wd); end
   endtask

   task automatic test_bad_chk();
      pay[0] = 32'hE3000001;
      pay[1] = 32'hE3A00002;
      @(posedge clk);
      clear_log();
      send_frame(8'd2, 2, 8'h01, 0);
      @(negedge clk);
      n_checks++;
      if (bus.error !== 1'b1) begin n_fail++; $display("FAIL bad_chk error: got %b want 1", bus.error); end
      n_checks++;
      if (bus.core_reset !== 1'b1) begin n_fail++; $display("FAIL bad_chk core_reset: got %b want 1", bus.core_reset); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL bad_chk done: got %b want 0", bus.done); end
      n_checks++;
      if (wr_data.size() !== 2) begin
         n_fail++; $display("FAIL bad_chk write_count: got %0d want 2", wr_data.size());
      end else begin
         n_checks++;
         if (wr_data[1] !== 32'hE3A00002) begin n_fail++; $display("FAIL bad_chk data[1]: got %08h want E3A00002", wr_data[1]); end
      end
      @(posedge clk);
      clear_log();
      send_frame(8'd2, 2, 8'h00, 0);
      @(negedge clk);
      n_checks++;
      if (bus.error !== 1'b0) begin n_fail++; $display("FAIL bad_chk retry error: got %b want 0", bus.error); end
      n_checks++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bad_chk retry done: got %b want 1", bus.done); end
      n_checks++;
      if (wr_data.size() !== 2) begin n_fail++; $display("FAIL bad_chk retry write_count: got %0d want 2", wr_data.size()); end
   endtask

   task automatic test_illegal_count();
      int xc;
      @(posedge clk);
      clear_log();
      send_byte(8'hA5, xc);
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.core_reset !== 1'b1) begin
         n_fail++; $display("FAIL restart from done: got done=%b core_reset=%b want 0/1", bus.done, bus.core_reset);
      end
      send_byte(8'h00, xc);
      @(negedge clk);
      n_checks++;
      if (bus.error !== 1'b1) begin n_fail++; $display("FAIL count_zero error: got %b want 1", bus.error); end
      send_byte(8'hA5, xc);
      @(negedge clk);
      n_checks++;
      if (bus.error !== 1'b0) begin n_fail++; $display("FAIL err_retry error: got %b want 0", bus.error); end
      send_byte(8'h41, xc);
      @(negedge clk);
      n_checks++;
      if (bus.error !== 1'b1 || bus.core_reset !== 1'b1) begin
         n_fail++; $display("FAIL count_65: got error=%b core_reset=%b want 1/1", bus.error, bus.core_reset);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (wr_data.size() !== 0) begin n_fail++; $display("FAIL illegal_count writes: got %0d want 0", wr_data.size()); end

      // Junk in IDLE after a reset must be ignored.
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      send_byte(8'h00, xc);
      send_byte(8'hFF, xc);
      @(negedge clk);
      n_checks++;
      if (bus.error !== 1'b0 || bus.done !== 1'b0 || bus.core_reset !== 1'b1) begin
         n_fail++; $display("FAIL idle_junk: got error=%b done=%b core_reset=%b want 0/0/1", bus.error, bus.done, bus.core_reset);
      end
      pay[0] = 32'h12345678;
      send_frame(8'd1, 1, 8'h00, 0);
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL idle_junk load done: got %b want 1", bus.done); end
      n_checks++;
      if (wr_data.size() !== 1) begin
         n_fail++; $display("FAIL idle_junk write_count: got %0d want 1", wr_data.size());
      end else begin
         n_checks++;
         if (wr_data[0] !== 32'h12345678 || wr_addr[0] !== 6'd0) begin
            n_fail++; $display("FAIL idle_junk write: got %0d:%08h want 0:12345678", wr_addr[0], wr_data[0]);
         end
      end
   endtask

   task automatic test_stalls();
      int bad_a, bad_d, bad_l;
      // Distinct bytes 0..255, so loss or duplication shifts the data; 8'hA5
      // occurs inside the payload.
      for (int i = 0; i < 64; i++) begin
         pay[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      end
      @(posedge clk);
      clear_log();
      bp_viol = 0;
      send_frame(8'd64, 64, 8'h00, 3);
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL stalls done: got %b want 1", bus.done); end
      n_checks++;
      if (bp_viol !== 0) begin n_fail++; $display("FAIL stalls in_ready: %0d cycles with in_ready != ~imem_we, want 0", bp_viol); end
      n_checks++;
      if (wr_data.size() !== 64) begin
         n_fail++; $display("FAIL stalls write_count: got %0d want 64", wr_data.size());
      end else begin
         bad_a = 0; bad_d = 0; bad_l = 0;
         for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (wr_addr[i] !== 6'(i)) begin n_fail++; bad_a++; if (bad_a < 4) $display("FAIL stalls addr[%0d]: got %0d want %0d", i, wr_addr[i], i); end
            n_checks++;
            if (wr_data[i] !== pay[i]) begin n_fail++; bad_d++; if (bad_d < 4) $display("FAIL stalls data[%0d]: got %08h want %08h", i, wr_data[i], pay[i]); end
            n_checks++;
            if (wr_cyc[i] !== xfer4_cyc[i] + 1) begin n_fail++; bad_l++; if (bad_l < 4) $display("FAIL stalls latency[%0d]: got cycle %0d want %0d", i, wr_cyc[i], xfer4_cyc[i] + 1); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int xc;
      logic [7:0] part [0:7];
      part = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      @(posedge clk);
      clear_log();
      for (int i = 0; i < 8; i++) send_byte(part[i], xc);
      // Reset coincides with an offered byte.
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      @(posedge clk);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.core_reset !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid status: got core_reset=%b done=%b error=%b want 1/0/0", bus.core_reset, bus.done, bus.error);
      end
      n_checks++;
      if (bus.imem_we !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid port: got imem_we=%b in_ready=%b want 0/1", bus.imem_we, bus.in_ready);
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (wr_data.size() !== 1) begin
         n_fail++; $display("FAIL reset_mid write_count: got %0d want 1", wr_data.size());
      end else begin
         n_checks++;
         if (wr_data[0] !== 32'h44332211) begin n_fail++; $display("FAIL reset_mid partial word: got %08h want 44332211", wr_data[0]); end
      end
      pay[0] = 32'hE3000001;
      pay[1] = 32'hE3A00002;
      @(posedge clk);
      clear_log();
      send_frame(8'd2, 2, 8'h00, 0);
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1 || bus.core_reset !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid reload: got done=%b core_reset=%b want 1/0", bus.done, bus.core_reset);
      end
      n_checks++;
      if (wr_data.size() !== 2) begin
         n_fail++; $display("FAIL reset_mid reload write_count: got %0d want 2", wr_data.size());
      end else begin
         n_checks++;
         if (wr_data[0] !== 32'hE3000001 || wr_data[1] !== 32'hE3A00002) begin
            n_fail++; $display("FAIL reset_mid reload data: got %08h %08h want E3000001 E3A00002", wr_data[0], wr_data[1]);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_two_word();
      test_bad_chk();
      test_illegal_count();
      test_stalls();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It receives a framed byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. It writes those words into the instruction RAM's write port and holds the ARM core in reset until a complete, checksum-verified image is in place. It sits between the host link and the instruction memory, alongside the core's reset input.

## Interface
Parameters:
- `DEPTH`, default 64: instruction RAM depth in words; must be a power of two, at most 256.
- `MAGIC`, default 8'hA5: frame start byte.

Ports:
- `clk`, input, 1: single clock.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: byte available.
- `in_data`, input, 8: byte value.
- `in_ready`, output, 1: loader accepts a byte this cycle. A byte transfers when `in_valid & in_ready`.
- `imem_we`, output, 1: one-cycle word write strobe.
- `imem_addr`, output, $clog2(DEPTH): word address.
- `imem_wd`, output, 32: word data.
- `core_reset`, output, 1: holds the core in reset while high.
- `done`, output, 1: last frame loaded and verified.
- `error`, output, 1: last frame rejected.

## Operation
Frame format: `MAGIC`, then COUNT (1 byte, number of words), then COUNT×4 payload bytes (least significant byte first), then CHK (the XOR of all payload bytes).

States:
- **IDLE**: a non-`MAGIC` byte is dropped. `MAGIC` → COUNT; on that transfer `core_reset`=1 and `done`=`error`=0.
- **COUNT**:
  - COUNT=0 or COUNT>`DEPTH` → ERR.
  - Otherwise latch COUNT, clear the word index, byte index and checksum → DATA.
- **DATA**:
  - Each byte goes into the assembler at its byte index (0..3); checksum ^= byte.
  - On byte index 3: the next cycle drives `imem_we`=1, `imem_addr`=word index, `imem_wd`=assembled word; the word index increments.
  - After word COUNT-1 completes → CHECK.
- **CHECK**:
  - CHK == checksum → DONE.
  - Mismatch → ERR.
- **DONE**: `done`=1 and `core_reset`=0. A byte equal to `MAGIC` restarts the load (→ COUNT, `core_reset`=1, `done`=0). Other bytes are dropped.
- **ERR**: `error`=1 and `core_reset`=1. `MAGIC` retries (→ COUNT, `error`=0). Other bytes are dropped.

Rules:
- `in_ready`=1 in every state except the single cycle in which `imem_we` is asserted.
- Back-to-back words therefore cost 5 cycles minimum.
- Words already written before an error are not erased. The core stays in reset, so it never runs them.
- The word index never wraps, because COUNT ≤ `DEPTH` is enforced in COUNT.
- `imem_addr` and `imem_wd` hold their last values when `imem_we`=0.

## Timing
Reset values (after the first `clk` edge with `reset`=1):
- State IDLE.
- `in_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wd`=0.
- `core_reset`=1, `done`=0, `error`=0.

Latency:
- `imem_we` rises exactly 1 cycle after the transfer of a word's 4th byte.
- `core_reset` falls and `done` rises 1 cycle after the transfer of a matching CHK.
- `error` rises 1 cycle after a bad CHK or an illegal COUNT.

Other rules:
- `in_valid` may drop mid-frame. The loader waits indefinitely and has no timeout.
- `reset` mid-frame aborts the load: IDLE, `core_reset`=1, and partially written RAM is left as is.
- `reset` has priority over a simultaneous byte transfer.
- A `MAGIC` byte inside DATA is payload, not a restart.

## Structure
- Package `loader_pkg`:
  - `loader_state_t` enum (IDLE, COUNT, DATA, CHECK, DONE, ERR).
  - Default `MAGIC` constant.
- Sub-module `byte_assembler`:
  - Inputs: byte, 2-bit index, load enable, clear.
  - Output: 32-bit word register; byte index k fills bits [8k+7:8k].
- The top level holds the FSM, the counters, the checksum register and the output registers.

## Test plan
- **Reset:** hold `reset` 2 cycles → `core_reset`=1, `done`=0, `error`=0, `imem_we`=0, `in_ready`=1.
- **Two-word load, valid checksum:**
  - Stimulus: A5 02 01 00 00 E3 02 00 A0 E3 CHK, where CHK = XOR of the eight payload bytes.
  - Response: writes addr0=E3000001 and addr1=E3A00002, each `imem_we` one cycle wide and 1 cycle after its 4th byte; `done`=1 and `core_reset`=0 one cycle after CHK.
- **Bad checksum:**
  - Stimulus: the same frame with CHK^8'h01.
  - Response: both words are written, then `error`=1, `core_reset` stays 1 and `done`=0.
  - Follow-up: a correct frame afterwards → `error`=0, `done`=1.
- **Illegal COUNT and junk:**
  - A5 00 → ERR.
  - A5 41 (65 > `DEPTH`) → ERR with no `imem_we`.
  - Bytes 00 FF in IDLE → dropped, state stays IDLE.
- **Stalls and backpressure:**
  - Random `in_valid` gaps in a 64-word frame → 64 writes to addresses 0..63 in order.
  - `in_ready`=0 exactly during each `imem_we` cycle.
  - Verify a byte held valid across the stall is not lost or duplicated.
- **Reset mid-frame:**
  - Stimulus: `reset` after 6 payload bytes.
  - Response: IDLE, no further writes, `core_reset`=1.
  - Follow-up: a fresh frame loads correctly.
